seq_detector_param: RTL and testbench

//  Parametrised serial bit-pattern detector, next generation of the fixed 10010 seqdet.

---
 rtl/seq_detector_param.sv | 113 +++++++++++
 tb/tb_seq_detector_param.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// seq_detector_param: serial bit-pattern detector with a runtime-loadable
// pattern and length, overlapping/non-overlapping modes and a saturating
// match counter. The first received bit lines up with the pattern MSB
// (bit [len-1]). The newest bit sits in the window LSB.
module seq_detector_param #(
  parameter int unsigned       PAT_W   = 8,
  parameter int unsigned       LEN_W   = 4,
  parameter int unsigned       CNT_W   = 8,
  parameter logic [PAT_W-1:0]  DEF_PAT = 8'h12,
  parameter int unsigned       DEF_LEN = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_value,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             overlap_en,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic [LEN_W-1:0] fill
);

  logic [PAT_W-1:0] pat_q;
  logic [PAT_W-1:0] hist_q;
  logic [PAT_W-1:0] hist_n;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_clamped;
  logic [LEN_W-1:0] fill_q;
  logic [LEN_W-1:0] fill_n;
  logic [LEN_W-1:0] fill_beat;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_n;
  logic             match_q;
  logic             match_n;
  logic             hit;

  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign fill      = fill_q;

  // Clamp an oversized requested length to the window depth.
  always_comb begin
    len_clamped = pat_len;
    if (pat_len > LEN_W'(PAT_W)) begin
      len_clamped = LEN_W'(PAT_W);
    end
  end

  // Next window/fill, hit detection on the updated window, counter update.
  always_comb begin
    hist_n    = hist_q;
    fill_n    = fill_q;
    fill_beat = '0;
    hit       = 1'b0;
    cnt_n     = cnt_q;
    // Only the low len bits take part in the compare.
    mask      = ~({PAT_W{1'b1}} << len_q);

    if (pat_load) begin
      // A load restarts detection; a bit presented in the same cycle is dropped.
      hist_n = '0;
      fill_n = '0;
    end else if (in_valid) begin
      hist_n = {hist_q[PAT_W-2:0], in_bit};
      if (len_q == '0) begin
        fill_beat = '0;
      end else if (fill_q < len_q) begin
        fill_beat = fill_q + LEN_W'(1);
      end else begin
        fill_beat = fill_q;
      end
      hit    = (len_q != '0) && (fill_beat == len_q) &&
               ((hist_n & mask) == (pat_q & mask));
      // Non-overlapping mode needs len fresh bits before the next hit.
      fill_n = (hit && !overlap_en) ? '0 : fill_beat;
    end

    match_n = hit;

    // Clear takes effect first, so a coincident hit leaves the count at one.
    if (cnt_clr) begin
      cnt_n = hit ? CNT_W'(1) : '0;
    end else if (hit && (cnt_q != '1)) begin
      cnt_n = cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset; pattern/length latched on load.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q   <= DEF_PAT;
      len_q   <= LEN_W'(DEF_LEN);
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      hist_q  <= hist_n;
      fill_q  <= fill_n;
      match_q <= match_n;
      cnt_q   <= cnt_n;
      if (pat_load) begin
        pat_q <= pat_value;
        len_q <= len_clamped;
      end
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Testbench for seq_detector_param: directed bit streams, expected match
// counts queued at stimulus time and checked by a monitor on each match pulse.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_bit, pat_load, overlap_en, cnt_clr;
  logic       in_valid2, pat_load2, cnt_clr2;
  logic [7:0] pat_value;
  logic [3:0] pat_len;
  logic       match, match2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;
  logic [3:0] fill, fill2;

  int total = 0;
  int bad   = 0;
  int q1[$];
  int q2[$];
  int exp1 = 0;
  int exp2 = 0;
  int e1, e2;

  always #5 clk = ~clk;

  seq_detector_param dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .pat_load(pat_load), .pat_value(pat_value), .pat_len(pat_len),
    .overlap_en(overlap_en), .cnt_clr(cnt_clr),
    .match(match), .match_cnt(match_cnt), .fill(fill)
  );

  seq_detector_param #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_bit(in_bit),
    .pat_load(pat_load2), .pat_value(pat_value), .pat_len(pat_len),
    .overlap_en(overlap_en), .cnt_clr(cnt_clr2),
    .match(match2), .match_cnt(match_cnt2), .fill(fill2)
  );

  // Monitor: every match pulse must correspond to a queued expectation.
  always @(negedge clk) begin
    if (match !== 1'b0) begin
      total++;
      if (q1.size() == 0) begin
        bad++;
        $display("FAIL spurious_match1 got match=%b cnt=%0d expected no match", match, match_cnt);
      end else begin
        e1 = q1.pop_front();
        if (int'(match_cnt) != e1) begin
          bad++;
          $display("FAIL match_cnt1 got=%0d expected=%0d", match_cnt, e1);
        end
      end
    end
    if (match2 !== 1'b0) begin
      total++;
      if (q2.size() == 0) begin
        bad++;
        $display("FAIL spurious_match2 got match=%b cnt=%0d expected no match", match2, match_cnt2);
      end else begin
        e2 = q2.pop_front();
        if (int'(match_cnt2) != e2) begin
          bad++;
          $display("FAIL match_cnt2 got=%0d expected=%0d", match_cnt2, e2);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    exp1 = 0;
    exp2 = 0;
  endtask

  task automatic load(input logic [7:0] v, input logic [3:0] l);
    pat_value = v;
    pat_len   = l;
    pat_load  = 1'b1;
    tick();
    pat_load  = 1'b0;
  endtask

  task automatic load2(input logic [7:0] v, input logic [3:0] l);
    pat_value = v;
    pat_len   = l;
    pat_load2 = 1'b1;
    tick();
    pat_load2 = 1'b0;
  endtask

  // One beat into dut; if a hit is expected, queue the new counter value.
  task automatic beat(input logic b, input logic hit, input int gap);
    in_valid = 1'b1;
    in_bit   = b;
    if (hit) begin
      if (exp1 < 255) exp1++;
      q1.push_back(exp1);
    end
    tick();
    in_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic beat2(input logic b, input logic hit, input logic clr);
    in_valid2 = 1'b1;
    in_bit    = b;
    cnt_clr2  = clr;
    if (clr) exp2 = hit ? 1 : 0;
    else if (hit && exp2 < 3) exp2++;
    if (hit) q2.push_back(exp2);
    tick();
    in_valid2 = 1'b0;
    cnt_clr2  = 1'b0;
  endtask

  // bits sent MSB-first; hits[i] set means a hit after bit i (0-based).
  task automatic send_seq(input logic [31:0] bits, input int n, input logic [31:0] hits, input int gap);
    for (int i = 0; i < n; i++) begin
      beat(bits[n-1-i], hits[i], gap);
    end
  endtask

  task automatic drain(input string name);
    repeat (2) tick();
    chk(name, q1.size() + q2.size(), 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; pat_load = 1'b0;
    overlap_en = 1'b1; cnt_clr = 1'b0; in_valid2 = 1'b0; pat_load2 = 1'b0;
    cnt_clr2 = 1'b0; pat_value = '0; pat_len = '0;
    repeat (2) tick();
    do_reset();
    chk("reset_match", int'(match), 0);
    chk("reset_cnt", int'(match_cnt), 0);
    chk("reset_fill", int'(fill), 0);

    // Test 1: default 10010, overlapping
    overlap_en = 1'b1;
    send_seq(32'h000C_9494, 20, 32'h0001_2120, 0);
    drain("t1_drain");
    chk("t1_cnt", int'(match_cnt), 4);

    // Test 2: same stream, non-overlapping
    do_reset();
    overlap_en = 1'b0;
    send_seq(32'h000C_9494, 20, 32'h0000_2020, 0);
    drain("t2_drain");
    chk("t2_cnt", int'(match_cnt), 2);

    // Test 3: full-width pattern, back-to-back then with gaps
    do_reset();
    overlap_en = 1'b1;
    load(8'hB7, 4'd8);
    send_seq(32'h0000_B7B7, 16, 32'h0000_8080, 0);
    drain("t3_drain");
    chk("t3_cnt", int'(match_cnt), 2);
    do_reset();
    load(8'hB7, 4'd8);
    send_seq(32'h0000_B7B7, 16, 32'h0000_8080, 3);
    drain("t3_gap_drain");
    chk("t3_gap_cnt", int'(match_cnt), 2);

    // Test 4: length 0 disables, oversized length clamps
    do_reset();
    load(8'h00, 4'd0);
    for (int i = 0; i < 20; i++) beat(1'($urandom_range(0, 1)), 1'b0, 0);
    chk("t4_len0_fill", int'(fill), 0);
    drain("t4_len0_drain");
    load(8'hB7, 4'd12);
    send_seq(32'h0000_00B7, 8, 32'h0000_0080, 0);
    drain("t4_clamp_drain");
    chk("t4_clamp_fill", int'(fill), 8);

    // Test 5: 2-bit counter, length-1 pattern
    do_reset();
    overlap_en = 1'b1;
    load2(8'h01, 4'd1);
    for (int i = 0; i < 6; i++) beat2(1'b1, 1'b1, 1'b0);
    beat2(1'b1, 1'b1, 1'b1);
    overlap_en = 1'b0;
    beat2(1'b1, 1'b1, 1'b0);
    chk("t5_fill_after_hit", int'(fill2), 0);
    beat2(1'b0, 1'b0, 1'b0);
    chk("t5_fill_no_hit", int'(fill2), 1);
    beat2(1'b1, 1'b1, 1'b0);
    drain("t5_drain");
    chk("t5_cnt", int'(match_cnt2), 3);
    cnt_clr2 = 1'b1;
    tick();
    cnt_clr2 = 1'b0;
    chk("t5_clr", int'(match_cnt2), 0);

    // Test 6: reset mid-stream, then load coincident with completing bit
    do_reset();
    overlap_en = 1'b1;
    send_seq(32'h4, 3, 32'h0, 0);
    do_reset();
    chk("t6_fill_after_rst", int'(fill), 0);
    send_seq(32'h2, 2, 32'h0, 0);
    chk("t6_fill2", int'(fill), 2);
    drain("t6_no_match");
    send_seq(32'h2, 3, 32'h4, 0);
    send_seq(32'h9, 4, 32'h0, 0);
    pat_value = 8'h12;
    pat_len   = 4'd5;
    pat_load  = 1'b1;
    in_valid  = 1'b1;
    in_bit    = 1'b0;
    tick();
    pat_load  = 1'b0;
    in_valid  = 1'b0;
    chk("t6_load_fill", int'(fill), 0);
    drain("t6_load_drain");
    send_seq(32'h12, 5, 32'h10, 0);
    drain("t6_final_drain");
    chk("t6_cnt", int'(match_cnt), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
